serial_sub2: RTL
================

Name: serial_sub2

Overview:
- Sequential N-bit unsigned subtractor, D = A - B.
- Processes one radix-4 digit (2 bits) per clock, LSB digit first, with a registered borrow.
- Counterpart to the 2-bit carry adder slice: same digit width, opposite arithmetic direction (borrow instead of carry).
- Used where a full-width combinational subtractor is too large; a start/done handshake frames each operation.

Parameters:
- N, 8, operand width in bits; must be even and >= 2. Digit count is N/2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only in IDLE or DONE
- A  input  N  minuend; sampled on the accepting start edge only
- B  input  N  subtrahend; sampled on the accepting start edge only
- busy  output  1  high while digits are being processed (RUN)
- done  output  1  one-cycle pulse; D/bout/zero valid from this cycle
- D  output  N  difference, modulo 2^N
- bout  output  1  final borrow; 1 iff A < B unsigned
- zero  output  1  1 iff D == 0

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, D=0, bout=0, zero=1, borrow=0, digit counter=0, operand shift registers cleared.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at an edge: load A and B into shift registers, borrow<=0, counter<=0, go RUN.
  - start=0: stay in IDLE.
- RUN: busy=1. Each edge:
  - Take low digits a=Areg[1:0], b=Breg[1:0].
  - Compute t = a - b - borrow (3-bit signed).
  - Digit result = t[1:0]; borrow <= (t < 0).
  - Shift both operand registers right by 2.
  - Shift the digit result into the partial result register from the MSB end.
  - counter increments.
- RUN exit: on the edge that processes digit N/2-1:
  - Copy the completed partial result to D.
  - bout <= borrow produced by that digit.
  - zero <= (completed result == 0).
  - Go DONE.
- DONE: done=1, busy=0 for exactly one cycle.
  - Next edge with start=1: accept a new operation (reload, go RUN). Back-to-back operation with no IDLE cycle.
  - Otherwise: go IDLE.
- Latency: start accepted at edge 0; done high in the cycle after edge N/2. N=8 gives done after edge 4.
- Throughput: one result per N/2+1 cycles when start is held high.
- start during RUN is ignored. A/B changes during RUN have no effect.
- D, bout and zero are registered. They hold the last result through IDLE and through a following RUN, and update only on the RUN->DONE edge.
- Arithmetic check: D equals (A - B) mod 2^N. bout equals the borrow out of the MSB digit. Digit results never exceed 2 bits.
- Reset asserted mid-RUN: operation is abandoned, all outputs return to reset values, and no done pulse is produced. After reset releases, the block is in IDLE and accepts start on the first edge.
- Reset asserted in DONE: done drops immediately, without waiting for a clock edge.
- N=2 (one digit): RUN lasts one edge; done occurs after edge 1.
- Unknown or illegal state encoding: recover to IDLE on the next edge.

Test Plan:
- N=8. Reset, then A=0x5A, B=0x3C, start pulse -> done after 4 RUN edges; D=0x1E, bout=0, zero=0; busy high for exactly 4 cycles.
- A=0x10, B=0x20 -> D=0xF0, bout=1, zero=0. A=0x00, B=0x01 -> D=0xFF, bout=1 (borrow ripples through all 4 digits).
- A=0xA7, B=0xA7 -> D=0x00, bout=0, zero=1. A=0xFF, B=0x00 -> D=0xFF, bout=0.
- Hold start high with A=0x33, B=0x11 then A=0x04, B=0x09 changed during DONE:
  - First done: D=0x22, bout=0.
  - Second operation starts with no IDLE cycle; second done 5 cycles later with D=0xFB, bout=1.
  - A/B toggled and start pulsed during RUN must not alter either result.
- Start A=0x80, B=0x01; assert rst after edge 2 -> busy=0, done=0, D=0, zero=1 immediately; no done pulse. After release, A=0x09, B=0x03 -> D=0x06.
- Random sweep of 2000 operand pairs vs. reference model (A-B mod 256, A<B) -> zero mismatches; done pulses exactly once per accepted start.

Source files
------------

// File: rtl/serial_sub2.sv
// Digit-serial unsigned subtractor: D = A - B, one radix-4 digit per clock, LSB first.
// A start/done handshake frames each operation; results are held until the next completes.
module serial_sub2 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] D,
  output logic         bout,
  output logic         zero
);

  localparam int ND = N / 2;
  localparam int CW = (ND > 1) ? $clog2(ND) : 1;
  localparam logic [CW-1:0] LAST = CW'(ND - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [N-1:0]   areg;
  logic [N-1:0]   breg;
  logic [N-1:0]   pres;
  logic [N-1:0]   pres_nx;
  logic           borrow;
  logic [CW-1:0]  cnt;
  logic [2:0]     t;

  // Digit difference is 3-bit two's complement; bit 2 is the borrow out.
  always_comb begin
    t = {1'b0, areg[1:0]} - {1'b0, breg[1:0]} - {2'b00, borrow};
    pres_nx = pres >> 2;
    pres_nx[N-1 -: 2] = t[1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      D      <= '0;
      bout   <= 1'b0;
      zero   <= 1'b1;
      borrow <= 1'b0;
      cnt    <= '0;
      areg   <= '0;
      breg   <= '0;
      pres   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            areg   <= A;
            breg   <= B;
            pres   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          areg   <= areg >> 2;
          breg   <= breg >> 2;
          pres   <= pres_nx;
          borrow <= t[2];
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            D     <= pres_nx;
            bout  <= t[2];
            zero  <= (pres_nx == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
